// File: rtl/zx_bus_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : zx_bus_update_sequencer
// Brief    : Drives the CPLD register-load bus (DI + MX/MY/MKEY/JOY strobes)
//            for mouse/joystick updates and shifts queued keyboard-matrix
//            events out over the DAT/SK/STB serial link.
// Revision : 1.0 - initial release
// ============================================================================
module zx_bus_update_sequencer #(
  parameter int BUS_PHASE      = 2,
  parameter int SK_HALF        = 2,
  parameter int KEY_FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mouse_valid,
  input  logic [7:0] mouse_x,
  input  logic [7:0] mouse_y,
  input  logic [7:0] mouse_btn,
  output logic       mouse_ready,
  input  logic       joy_valid,
  input  logic [7:0] joy_data,
  output logic       joy_ready,
  input  logic       key_valid,
  input  logic [6:0] key_addr,
  input  logic       key_state,
  output logic       key_ready,
  output logic [7:0] DI,
  output logic       MX,
  output logic       MY,
  output logic       MKEY,
  output logic       JOY,
  output logic       DAT,
  output logic       SK,
  output logic       STB,
  output logic       bus_busy,
  output logic       key_busy
);

  localparam int c_BP_W = (BUS_PHASE > 1) ? $clog2(BUS_PHASE) : 1;
  localparam int c_SK_W = (SK_HALF > 1) ? $clog2(SK_HALF) : 1;
  localparam int c_AW   = $clog2(KEY_FIFO_DEPTH);
  localparam int c_PW   = c_AW + 1;

  localparam logic [c_BP_W-1:0] c_BP_LAST   = c_BP_W'(BUS_PHASE - 1);
  localparam logic [c_SK_W-1:0] c_SK_LAST   = c_SK_W'(SK_HALF - 1);
  localparam logic [c_PW-1:0]   c_FIFO_FULL = c_PW'(KEY_FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // Parallel bus engine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_SETUP = 2'd1,
    P_PULSE = 2'd2,
    P_HOLD  = 2'd3
  } p_state_t;

  p_state_t               r_p_state, w_p_state_nxt;
  logic [c_BP_W-1:0]      r_p_cnt, w_p_cnt_nxt;
  logic [1:0]             r_p_idx, w_p_idx_nxt;
  logic                   r_p_mouse, w_p_mouse_nxt;
  logic [2:0][7:0]        r_p_bytes, w_p_bytes_nxt;
  logic                   r_ptr_joy, w_ptr_joy_nxt;
  logic                   w_grant_mouse, w_grant_joy;
  logic                   w_hs_mouse, w_hs_joy;
  logic                   w_p_cnt_done;
  logic [1:0]             w_p_last_idx;
  logic [7:0]             w_di_nxt;
  logic [3:0]             w_lstb_nxt;   // {JOY, MKEY, MY, MX}

  assign w_grant_mouse = mouse_valid && (!joy_valid || !r_ptr_joy);
  assign w_grant_joy   = joy_valid && (!mouse_valid || r_ptr_joy);
  assign mouse_ready   = (r_p_state == P_IDLE) && w_grant_mouse;
  assign joy_ready     = (r_p_state == P_IDLE) && w_grant_joy;
  assign w_hs_mouse    = mouse_valid && mouse_ready;
  assign w_hs_joy      = joy_valid && joy_ready;
  assign w_p_cnt_done  = (r_p_cnt == c_BP_LAST);
  assign w_p_last_idx  = r_p_mouse ? 2'd2 : 2'd0;

  always_comb begin
    w_p_state_nxt = r_p_state;
    w_p_cnt_nxt   = r_p_cnt;
    w_p_idx_nxt   = r_p_idx;
    w_p_mouse_nxt = r_p_mouse;
    w_p_bytes_nxt = r_p_bytes;
    w_ptr_joy_nxt = r_ptr_joy;
    case (r_p_state)
      P_IDLE: begin
        if (w_hs_mouse) begin
          w_p_state_nxt = P_SETUP;
          w_p_cnt_nxt   = '0;
          w_p_idx_nxt   = 2'd0;
          w_p_mouse_nxt = 1'b1;
          w_p_bytes_nxt = {mouse_btn, mouse_y, mouse_x};
          w_ptr_joy_nxt = 1'b1;
        end else if (w_hs_joy) begin
          w_p_state_nxt = P_SETUP;
          w_p_cnt_nxt   = '0;
          w_p_idx_nxt   = 2'd0;
          w_p_mouse_nxt = 1'b0;
          w_p_bytes_nxt = {8'hFF, 8'hFF, joy_data};
          w_ptr_joy_nxt = 1'b0;
        end
      end
      P_SETUP: begin
        if (w_p_cnt_done) begin
          w_p_state_nxt = P_PULSE;
          w_p_cnt_nxt   = '0;
        end else begin
          w_p_cnt_nxt = r_p_cnt + c_BP_W'(1);
        end
      end
      P_PULSE: begin
        if (w_p_cnt_done) begin
          w_p_state_nxt = P_HOLD;
          w_p_cnt_nxt   = '0;
        end else begin
          w_p_cnt_nxt = r_p_cnt + c_BP_W'(1);
        end
      end
      P_HOLD: begin
        if (w_p_cnt_done) begin
          w_p_cnt_nxt = '0;
          if (r_p_idx == w_p_last_idx) begin
            w_p_state_nxt = P_IDLE;
          end else begin
            w_p_state_nxt = P_SETUP;
            w_p_idx_nxt   = r_p_idx + 2'd1;
          end
        end else begin
          w_p_cnt_nxt = r_p_cnt + c_BP_W'(1);
        end
      end
      default: w_p_state_nxt = P_IDLE;
    endcase
  end

  // Bus outputs are registered from the next-state view so DI and the strobe
  // change on the same edge as the phase they belong to.
  always_comb begin
    w_di_nxt   = 8'hFF;
    w_lstb_nxt = 4'b0000;
    if (w_p_state_nxt != P_IDLE) begin
      case (w_p_idx_nxt)
        2'd1:    w_di_nxt = w_p_bytes_nxt[1];
        2'd2:    w_di_nxt = w_p_bytes_nxt[2];
        default: w_di_nxt = w_p_bytes_nxt[0];
      endcase
    end
    if (w_p_state_nxt == P_PULSE) begin
      w_lstb_nxt = w_p_mouse_nxt ? (4'b0001 << w_p_idx_nxt) : 4'b1000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_state             <= P_IDLE;
      r_p_cnt               <= '0;
      r_p_idx               <= 2'd0;
      r_p_mouse             <= 1'b0;
      r_p_bytes             <= '1;
      r_ptr_joy             <= 1'b0;
      DI                    <= 8'hFF;
      {JOY, MKEY, MY, MX}   <= 4'b0000;
      bus_busy              <= 1'b0;
    end else begin
      r_p_state             <= w_p_state_nxt;
      r_p_cnt               <= w_p_cnt_nxt;
      r_p_idx               <= w_p_idx_nxt;
      r_p_mouse             <= w_p_mouse_nxt;
      r_p_bytes             <= w_p_bytes_nxt;
      r_ptr_joy             <= w_ptr_joy_nxt;
      DI                    <= w_di_nxt;
      {JOY, MKEY, MY, MX}   <= w_lstb_nxt;
      bus_busy              <= (w_p_state_nxt != P_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Keyboard event FIFO
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_STROBE = 3'd3,
    S_GAP    = 3'd4
  } s_state_t;

  s_state_t               r_s_state, w_s_state_nxt;
  logic [7:0]             r_fifo [KEY_FIFO_DEPTH];
  logic [c_PW-1:0]        r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic                   w_full, w_empty, w_push, w_pop;
  logic [7:0]             w_s_head;

  assign w_full       = ((r_wr_ptr - r_rd_ptr) == c_FIFO_FULL);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign key_ready    = !w_full;
  assign w_push       = key_valid && !w_full;
  assign w_pop        = (r_s_state == S_IDLE) && !w_empty;
  assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + c_PW'(1)) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PW'(1)) : r_rd_ptr;
  assign w_s_head     = r_fifo[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr[c_AW-1:0]] <= {key_addr, key_state};
    end
  end

  // --------------------------------------------------------------------------
  // Serial keyboard engine
  // --------------------------------------------------------------------------
  logic [c_SK_W-1:0]      r_s_cnt, w_s_cnt_nxt;
  logic [2:0]             r_s_bit, w_s_bit_nxt;
  logic                   r_s_high, w_s_high_nxt;
  logic [6:0]             r_s_addr, w_s_addr_nxt;
  logic                   r_s_val, w_s_val_nxt;
  logic                   w_s_cnt_done;
  logic [6:0]             w_s_shift;
  logic                   w_dat_nxt, w_sk_nxt, w_stb_nxt;

  assign w_s_cnt_done = (r_s_cnt == c_SK_LAST);

  always_comb begin
    w_s_state_nxt = r_s_state;
    w_s_cnt_nxt   = r_s_cnt;
    w_s_bit_nxt   = r_s_bit;
    w_s_high_nxt  = r_s_high;
    w_s_addr_nxt  = r_s_addr;
    w_s_val_nxt   = r_s_val;
    case (r_s_state)
      S_IDLE: begin
        if (w_pop) begin
          w_s_state_nxt = S_ADDR;
          w_s_cnt_nxt   = '0;
          w_s_bit_nxt   = 3'd0;
          w_s_high_nxt  = 1'b0;
          w_s_addr_nxt  = w_s_head[7:1];
          w_s_val_nxt   = w_s_head[0];
        end
      end
      S_ADDR: begin
        if (w_s_cnt_done) begin
          w_s_cnt_nxt = '0;
          if (!r_s_high) begin
            w_s_high_nxt = 1'b1;
          end else begin
            w_s_high_nxt = 1'b0;
            if (r_s_bit == 3'd6) begin
              w_s_state_nxt = S_DATA;
            end else begin
              w_s_bit_nxt = r_s_bit + 3'd1;
            end
          end
        end else begin
          w_s_cnt_nxt = r_s_cnt + c_SK_W'(1);
        end
      end
      S_DATA, S_STROBE, S_GAP: begin
        if (w_s_cnt_done) begin
          w_s_cnt_nxt = '0;
          case (r_s_state)
            S_DATA:   w_s_state_nxt = S_STROBE;
            S_STROBE: w_s_state_nxt = S_GAP;
            default:  w_s_state_nxt = S_IDLE;
          endcase
        end else begin
          w_s_cnt_nxt = r_s_cnt + c_SK_W'(1);
        end
      end
      default: w_s_state_nxt = S_IDLE;
    endcase
  end

  // Address goes out MSB first: bit index n selects addr[6-n].
  assign w_s_shift = w_s_addr_nxt << w_s_bit_nxt;

  always_comb begin
    w_dat_nxt = 1'b0;
    w_sk_nxt  = 1'b0;
    w_stb_nxt = 1'b0;
    case (w_s_state_nxt)
      S_ADDR: begin
        w_dat_nxt = w_s_shift[6];
        w_sk_nxt  = w_s_high_nxt;
      end
      S_DATA: w_dat_nxt = w_s_val_nxt;
      S_STROBE: begin
        w_dat_nxt = w_s_val_nxt;
        w_stb_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_state <= S_IDLE;
      r_s_cnt   <= '0;
      r_s_bit   <= 3'd0;
      r_s_high  <= 1'b0;
      r_s_addr  <= 7'd0;
      r_s_val   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      DAT       <= 1'b0;
      SK        <= 1'b0;
      STB       <= 1'b0;
      key_busy  <= 1'b0;
    end else begin
      r_s_state <= w_s_state_nxt;
      r_s_cnt   <= w_s_cnt_nxt;
      r_s_bit   <= w_s_bit_nxt;
      r_s_high  <= w_s_high_nxt;
      r_s_addr  <= w_s_addr_nxt;
      r_s_val   <= w_s_val_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      DAT       <= w_dat_nxt;
      SK        <= w_sk_nxt;
      STB       <= w_stb_nxt;
      key_busy  <= (w_s_state_nxt != S_IDLE) || (w_wr_ptr_nxt != w_rd_ptr_nxt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zx_bus_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_zx_bus_update_sequencer
// Brief    : Self-checking bench: cycle-exact sequences plus scoreboards fed
//            at handshake time and drained by bus/serial output monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zx_bus_update_sequencer;
  localparam int BP    = 2;
  localparam int SKH   = 2;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       mouse_valid, joy_valid, key_valid, key_state;
  logic [7:0] mouse_x, mouse_y, mouse_btn, joy_data;
  logic [6:0] key_addr;
  logic       mouse_ready, joy_ready, key_ready;
  logic [7:0] DI;
  logic       MX, MY, MKEY, JOY, DAT, SK, STB, bus_busy, key_busy;

  always #5 clk = ~clk;

  zx_bus_update_sequencer #(.BUS_PHASE(BP), .SK_HALF(SKH), .KEY_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mouse_valid(mouse_valid), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .mouse_btn(mouse_btn), .mouse_ready(mouse_ready),
    .joy_valid(joy_valid), .joy_data(joy_data), .joy_ready(joy_ready),
    .key_valid(key_valid), .key_addr(key_addr), .key_state(key_state),
    .key_ready(key_ready),
    .DI(DI), .MX(MX), .MY(MY), .MKEY(MKEY), .JOY(JOY),
    .DAT(DAT), .SK(SK), .STB(STB), .bus_busy(bus_busy), .key_busy(key_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] stb;   // {JOY, MKEY, MY, MX}
    logic [7:0] di;
  } bus_exp_t;

  typedef struct {
    bit         is_mouse;
    logic [7:0] d0, d1, d2;
    int         exp_pulses;
  } bus_vec_t;

  bus_exp_t   pq[$];
  logic [7:0] kq[$];
  int         mon_rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h expected none (t=%0t)", name, act, $time);
  endtask

  // Parallel-bus monitor: each strobe rise is matched against the scoreboard.
  logic [3:0] mon_prev;
  int         mon_width;
  bus_exp_t   mon_e;
  always @(negedge clk) begin
    if (rst) begin
      mon_prev  = 4'b0;
      mon_width = 0;
    end else begin
      if ({JOY, MKEY, MY, MX} != 4'b0 && $countones({JOY, MKEY, MY, MX}) != 1)
        flag("strobe_onehot", {JOY, MKEY, MY, MX});
      if ({JOY, MKEY, MY, MX} != 4'b0 && mon_prev == 4'b0) begin
        mon_rises++;
        mon_width = 1;
        if (pq.size() == 0) flag("strobe_unexpected", {JOY, MKEY, MY, MX});
        else begin
          mon_e = pq.pop_front();
          check("strobe_id", {JOY, MKEY, MY, MX}, mon_e.stb);
          check("strobe_di", DI, mon_e.di);
        end
      end else if ({JOY, MKEY, MY, MX} != 4'b0) begin
        mon_width++;
      end else if (mon_prev != 4'b0) begin
        check("strobe_width", mon_width, BP);
      end
      mon_prev = {JOY, MKEY, MY, MX};
    end
  end

  // Serial monitor: shifts DAT on SK rise, closes the event on STB rise.
  logic       s_sk_prev, s_stb_prev, s_dat_prev;
  logic [6:0] s_sh;
  int         s_nbits;
  logic [7:0] s_e;
  always @(negedge clk) begin
    if (rst) begin
      s_sk_prev = 1'b0; s_stb_prev = 1'b0; s_dat_prev = 1'b0;
      s_sh = 7'd0; s_nbits = 0;
    end else begin
      if (SK && STB) flag("sk_stb_overlap", {SK, STB});
      if (SK && !s_sk_prev) begin
        s_sh = {s_sh[5:0], DAT};
        s_nbits++;
      end
      if (STB && !s_stb_prev) begin
        if (kq.size() == 0) flag("key_unexpected", {s_sh, s_dat_prev});
        else begin
          s_e = kq.pop_front();
          check("key_event", {s_nbits[7:0], s_sh, s_dat_prev}, {8'd7, s_e});
        end
        s_nbits = 0;
      end
      s_sk_prev = SK; s_stb_prev = STB; s_dat_prev = DAT;
    end
  end

  task automatic randomize_payload();
    mouse_x   = 8'($urandom);
    mouse_y   = 8'($urandom);
    mouse_btn = 8'($urandom);
  endtask

  task automatic wait_idle(input int maxc);
    int t = 0;
    while (t < maxc && (pq.size() != 0 || kq.size() != 0 || bus_busy || key_busy)) begin
      @(negedge clk);
      t++;
    end
    check("drain", {pq.size() == 0, kq.size() == 0, bus_busy, key_busy}, 4'b1100);
  endtask

  task automatic push_bus(input bit is_mouse, input logic [7:0] a, b, c);
    if (is_mouse) begin
      pq.push_back({4'b0001, a});
      pq.push_back({4'b0010, b});
      pq.push_back({4'b0100, c});
    end else begin
      pq.push_back({4'b1000, a});
    end
  endtask

  task automatic mouse_exact(input logic [7:0] x, y, b);
    logic [2:0][7:0] v;
    int idx, ph;
    v = {b, y, x};
    @(posedge clk); #1;
    mouse_valid = 1'b1; mouse_x = x; mouse_y = y; mouse_btn = b;
    @(negedge clk);
    check("mouse_hs_ready", {mouse_ready, joy_ready}, 2'b10);
    push_bus(1'b1, x, y, b);
    @(posedge clk); #1;
    mouse_valid = 1'b0;
    randomize_payload();
    for (int c = 1; c <= 9 * BP + 1; c++) begin
      @(negedge clk);
      if (c == 9 * BP + 1) begin
        check("mouse_end_di", DI, 8'hFF);
        check("mouse_end_busy", {bus_busy, JOY, MKEY, MY, MX}, 5'b0);
      end else begin
        idx = (c - 1) / (3 * BP);
        ph  = ((c - 1) % (3 * BP)) / BP;
        check("mouse_cyc_di", DI, v[idx]);
        check("mouse_cyc_stb", {JOY, MKEY, MY, MX}, (ph == 1) ? (4'b0001 << idx) : 4'b0000);
      end
    end
  endtask

  task automatic key_exact(input logic [6:0] a, input logic s);
    int k;
    logic ex_dat, ex_sk, ex_stb, ex_busy;
    @(posedge clk); #1;
    key_valid = 1'b1; key_addr = a; key_state = s;
    @(negedge clk);
    check("key_push_ready", {key_ready, key_busy}, 2'b10);
    kq.push_back({a, s});
    @(posedge clk); #1;
    key_valid = 1'b0;
    for (int t = 1; t <= 17 * SKH + 2; t++) begin
      @(negedge clk);
      k = t - 2;
      ex_dat = 1'b0; ex_sk = 1'b0; ex_stb = 1'b0; ex_busy = 1'b1;
      if (t == 1) ;
      else if (k < 14 * SKH) begin
        ex_dat = a[6 - k / (2 * SKH)];
        ex_sk  = (k % (2 * SKH)) >= SKH;
      end else if (k < 15 * SKH) ex_dat = s;
      else if (k < 16 * SKH) begin ex_stb = 1'b1; ex_dat = DAT; end
      else if (k >= 17 * SKH) ex_busy = 1'b0;
      check("key_cyc", {DAT, SK, STB, key_busy}, {ex_dat, ex_sk, ex_stb, ex_busy});
    end
  endtask

  task automatic do_bus(input bus_vec_t v);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (v.is_mouse) begin
      mouse_valid = 1'b1; mouse_x = v.d0; mouse_y = v.d1; mouse_btn = v.d2;
    end else begin
      joy_valid = 1'b1; joy_data = v.d0;
    end
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (v.is_mouse ? mouse_ready : joy_ready) begin ok = 1'b1; break; end
    end
    check("bus_hs", ok, 1'b1);
    if (ok) push_bus(v.is_mouse, v.d0, v.d1, v.d2);
    @(posedge clk); #1;
    mouse_valid = 1'b0; joy_valid = 1'b0;
    randomize_payload();
    joy_data = 8'($urandom);
  endtask

  bus_vec_t vecs[6];
  int       rises0, exp_pulses, nhs, acc, first_low, low_cycles;

  initial begin
    vecs[0] = '{1'b1, 8'h00, 8'hFF, 8'h80, 3};
    vecs[1] = '{1'b0, 8'hA5, 8'h00, 8'h00, 1};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1};
    vecs[3] = '{1'b1, 8'h7F, 8'h01, 8'hFE, 3};
    vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 3};
    vecs[5] = '{1'b0, 8'h5A, 8'h00, 8'h00, 1};

    rst = 1'b1;
    mouse_valid = 1'b0; joy_valid = 1'b0; key_valid = 1'b0;
    mouse_x = 8'h0; mouse_y = 8'h0; mouse_btn = 8'h0; joy_data = 8'h0;
    key_addr = 7'h0; key_state = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    check("rst_di", DI, 8'hFF);
    check("rst_outs", {JOY, MKEY, MY, MX, DAT, SK, STB}, 7'b0);
    check("rst_ready", {mouse_ready, joy_ready, key_ready}, 3'b001);
    check("rst_busy", {bus_busy, key_busy}, 2'b00);

    mouse_exact(8'h12, 8'h34, 8'hFA);
    key_exact(7'h24, 1'b1);

    // Both requesters held: strict alternation starting with mouse
    @(posedge clk); #1;
    rst = 1'b1; mouse_valid = 1'b1; joy_valid = 1'b1; joy_data = 8'h1F;
    randomize_payload();
    @(posedge clk); #1 rst = 1'b0;
    pq.delete(); kq.delete();
    nhs = 0;
    for (int t = 0; t < 200 && nhs < 4; t++) begin
      @(negedge clk);
      if (mouse_ready && joy_ready) flag("arb_both", 2'b11);
      else if (mouse_ready || joy_ready) begin
        check("arb_grant", mouse_ready, (nhs % 2) == 0);
        push_bus(mouse_ready, mouse_ready ? mouse_x : joy_data, mouse_y, mouse_btn);
        nhs++;
        @(posedge clk); #1;
        randomize_payload();
        if (nhs == 4) begin mouse_valid = 1'b0; joy_valid = 1'b0; end
      end
    end
    check("arb_count", nhs, 4);
    wait_idle(100);

    // Table of bus transfers
    rises0 = mon_rises;
    exp_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      do_bus(vecs[i]);
      exp_pulses += vecs[i].exp_pulses;
    end
    wait_idle(200);
    check("table_pulses", mon_rises - rises0, exp_pulses);

    // Ten keyboard events held back-to-back
    acc = 0; first_low = -1; low_cycles = 0;
    @(posedge clk); #1;
    key_valid = 1'b1; key_addr = 7'(5); key_state = 1'b0;
    for (int t = 0; t < 400 && acc < 10; t++) begin
      @(negedge clk);
      if (key_ready) begin
        kq.push_back({key_addr, key_state});
        acc++;
        @(posedge clk); #1;
        key_addr = 7'(acc * 13 + 5); key_state = acc[0];
        if (acc == 10) key_valid = 1'b0;
      end else begin
        if (first_low < 0) begin
          first_low = t;
          check("fifo_full_count", acc, DEPTH + 1);
        end
        low_cycles++;
      end
    end
    check("fifo_accepted", acc, 10);
    check("fifo_full_cycle", first_low, DEPTH + 1);
    check("fifo_low_cycles", low_cycles, 17 * SKH + 3 - (DEPTH + 1));
    wait_idle(1000);

    // Reset during MY pulse and serial ADDR
    @(posedge clk); #1;
    mouse_valid = 1'b1; mouse_x = 8'hA1; mouse_y = 8'hB2; mouse_btn = 8'hC3;
    key_valid = 1'b1; key_addr = 7'h55; key_state = 1'b1;
    @(negedge clk);
    check("rmid_hs", {mouse_ready, key_ready}, 2'b11);
    push_bus(1'b1, 8'hA1, 8'hB2, 8'hC3);
    kq.push_back({7'h55, 1'b1});
    @(posedge clk); #1;
    mouse_valid = 1'b0; key_addr = 7'h2A; key_state = 1'b0;
    @(negedge clk);
    kq.push_back({7'h2A, 1'b0});
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rmid_pre", {MY, SK, DI}, {1'b1, 1'b1, 8'hB2});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rmid_post", {JOY, MKEY, MY, MX, SK, STB, DAT, DI}, {7'b0, 8'hFF});
    check("rmid_flags", {key_busy, bus_busy, key_ready}, 3'b001);
    pq.delete(); kq.delete();
    repeat (5) @(negedge clk);
    check("rmid_flushed", {key_busy, SK, STB}, 3'b000);
    mouse_exact(8'h5A, 8'hC3, 8'h3C);
    key_exact(7'h5B, 1'b0);
    wait_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
